// File: rtl/uart_frame_counter_if.sv
// uart_frame_counter_if: per-channel control/status bundle for uart_frame_counter.
// Channel c occupies bit [c], or [c*W +: W] for multi-bit fields.
interface uart_frame_counter_if #(
  parameter int CHANNELS = 2,
  parameter int DATA_MAX = 9
);
  localparam int CNT_W = $clog2(DATA_MAX + 4);

  logic [CHANNELS-1:0]       start;
  logic [CHANNELS-1:0]       abort;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS*4-1:0]     data_bits;
  logic [CHANNELS-1:0]       parity_en;
  logic [CHANNELS-1:0]       two_stop;
  logic [CHANNELS-1:0]       busy;
  logic [CHANNELS-1:0]       done;
  logic [CHANNELS-1:0]       last_bit;
  logic [CHANNELS*CNT_W-1:0] bit_idx;
  logic [CHANNELS*2-1:0]     phase;

  // Channel side: drives frame control, observes frame position.
  modport master (
    output start, abort, tick, data_bits, parity_en, two_stop,
    input  busy, done, last_bit, bit_idx, phase
  );

  // Counter side.
  modport slave (
    input  start, abort, tick, data_bits, parity_en, two_stop,
    output busy, done, last_bit, bit_idx, phase
  );
endinterface

// File: rtl/uart_frame_counter.sv
// uart_frame_counter: per-channel UART frame bit-position counter.
// Each channel runs an independent IDLE/RUN FSM that latches the frame
// format on start and advances one bit per tick until the last stop bit.
// Optional feature macro: UART_FRAME_CNT_PARITY_EN (parity bit support).
module uart_frame_counter #(
  parameter int CHANNELS = 2,
  parameter int DATA_MAX = 9
) (
  input  logic              clock,
  input  logic              reset_n,
  uart_frame_counter_if.slave fc
);
  localparam int CNT_W = $clog2(DATA_MAX + 4);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q  [CHANNELS];
  state_t              state_d  [CHANNELS];
  logic [CNT_W-1:0]    cnt_q    [CHANNELS];
  logic [CNT_W-1:0]    cnt_d    [CHANNELS];
  logic [3:0]          dbits_q  [CHANNELS];
  logic [3:0]          dbits_d  [CHANNELS];
  logic [CNT_W-1:0]    last_idx [CHANNELS];
  logic [CHANNELS-1:0] stop2_q, stop2_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] par_eff;
`ifdef UART_FRAME_CNT_PARITY_EN
  logic [CHANNELS-1:0] parity_q, parity_d;
`endif

  logic [CHANNELS-1:0]       busy_w;
  logic [CHANNELS-1:0]       last_w;
  logic [CHANNELS*CNT_W-1:0] idx_w;
  logic [CHANNELS*2-1:0]     ph_w;

  // 0 data bits means 1; anything above DATA_MAX saturates.
  function automatic logic [3:0] clamp_bits(input logic [3:0] raw);
    if (raw == 4'd0) return 4'd1;
    if (int'(raw) > DATA_MAX) return 4'(DATA_MAX);
    return raw;
  endfunction

`ifdef UART_FRAME_CNT_PARITY_EN
  assign par_eff = parity_q;
`else
  assign par_eff = '0;
`endif

  // State, count, done and latched format registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
        dbits_q[c] <= 4'd1;
      end
      stop2_q  <= '0;
      done_q   <= '0;
`ifdef UART_FRAME_CNT_PARITY_EN
      parity_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dbits_q  <= dbits_d;
      stop2_q  <= stop2_d;
      done_q   <= done_d;
`ifdef UART_FRAME_CNT_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Index of the final stop bit (L-1) from the latched format.
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      last_idx[c] = CNT_W'(dbits_q[c]) + CNT_W'(par_eff[c])
                  + (stop2_q[c] ? CNT_W'(2) : CNT_W'(1));
    end
  end

  // Next state: abort beats start beats tick; done is a single-cycle pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dbits_d  = dbits_q;
    stop2_d  = stop2_q;
    done_d   = '0;
`ifdef UART_FRAME_CNT_PARITY_EN
    parity_d = parity_q;
`endif
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (fc.abort[c]) begin
        state_d[c] = IDLE;
        cnt_d[c]   = '0;
      end else if (fc.start[c]) begin
        state_d[c] = RUN;
        cnt_d[c]   = '0;
        dbits_d[c] = clamp_bits(fc.data_bits[c*4 +: 4]);
        stop2_d[c] = fc.two_stop[c];
`ifdef UART_FRAME_CNT_PARITY_EN
        parity_d[c] = fc.parity_en[c];
`endif
      end else if (fc.tick[c] && (state_q[c] == RUN)) begin
        if (cnt_q[c] == last_idx[c]) begin
          state_d[c] = IDLE;
          cnt_d[c]   = '0;
          done_d[c]  = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  // Outputs: position and phase decoded from count and latched format.
  always_comb begin
    busy_w = '0;
    last_w = '0;
    idx_w  = '0;
    ph_w   = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      busy_w[c]                 = (state_q[c] == RUN);
      last_w[c]                 = (state_q[c] == RUN) && (cnt_q[c] == last_idx[c]);
      idx_w[c*CNT_W +: CNT_W]   = cnt_q[c];
      if (cnt_q[c] == '0)
        ph_w[c*2 +: 2] = 2'd0;
      else if (cnt_q[c] <= CNT_W'(dbits_q[c]))
        ph_w[c*2 +: 2] = 2'd1;
      else if (par_eff[c] && (cnt_q[c] == CNT_W'(dbits_q[c]) + CNT_W'(1)))
        ph_w[c*2 +: 2] = 2'd2;
      else
        ph_w[c*2 +: 2] = 2'd3;
    end
  end

  assign fc.busy     = busy_w;
  assign fc.done     = done_q;
  assign fc.last_bit = last_w;
  assign fc.bit_idx  = idx_w;
  assign fc.phase    = ph_w;

endmodule

// File: tb/tb_uart_frame_counter.sv
// tb_uart_frame_counter: directed bench with reference model and scoreboard.
module tb_uart_frame_counter;
  localparam int CH = 2;
  localparam int DM = 9;
  localparam int CW = $clog2(DM + 4);

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  uart_frame_counter_if #(.CHANNELS(CH), .DATA_MAX(DM)) bus ();

  uart_frame_counter #(.CHANNELS(CH), .DATA_MAX(DM)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .fc      (bus)
  );

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          last;
    logic [CW-1:0] idx;
    logic [1:0]    ph;
  } obs_t;

  int tests = 0;
  int fails = 0;
  obs_t sb[$];
  string cur_tag = "reset";

  bit m_run  [CH];
  bit m_done [CH];
  int m_cnt  [CH];
  int m_D    [CH];
  int m_P    [CH];
  int m_S    [CH];
  int done_cnt [CH];
  int i;

  function automatic logic [CH-1:0] onehot(input int c);
    logic [CH-1:0] m;
    m = '0;
    m[c] = 1'b1;
    return m;
  endfunction

  function automatic obs_t model_obs(input int c);
    obs_t o;
    int   L;
    L      = 1 + m_D[c] + m_P[c] + m_S[c];
    o.busy = m_run[c];
    o.done = m_done[c];
    o.last = m_run[c] && (m_cnt[c] == L - 1);
    o.idx  = CW'(m_cnt[c]);
    if (m_cnt[c] == 0)                             o.ph = 2'd0;
    else if (m_cnt[c] <= m_D[c])                   o.ph = 2'd1;
    else if (m_P[c] == 1 && m_cnt[c] == m_D[c]+1)  o.ph = 2'd2;
    else                                           o.ph = 2'd3;
    return o;
  endfunction

  function automatic obs_t dut_obs(input int c);
    obs_t o;
    o.busy = bus.busy[c];
    o.done = bus.done[c];
    o.last = bus.last_bit[c];
    o.idx  = bus.bit_idx[c*CW +: CW];
    o.ph   = bus.phase[c*2 +: 2];
    return o;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_done[c] = 0; m_cnt[c] = 0;
      m_D[c] = 1; m_P[c] = 0; m_S[c] = 1;
    end
  endtask

  task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (busy,done,last,idx,phase)", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic fmt(input int c, input int db, input int pe, input int ts);
    bus.data_bits[c*4 +: 4] = 4'(db);
    bus.parity_en[c]        = pe[0];
    bus.two_stop[c]         = ts[0];
  endtask

  // Drive one cycle of strobes, predict, then compare after the edge.
  task automatic step(input logic [CH-1:0] st, input logic [CH-1:0] ab, input logic [CH-1:0] tk);
    obs_t e;
    int   d;
    @(negedge clock);
    bus.start = st; bus.abort = ab; bus.tick = tk;
    for (int c = 0; c < CH; c++) begin
      if (ab[c]) begin
        m_run[c] = 0; m_cnt[c] = 0; m_done[c] = 0;
      end else if (st[c]) begin
        d = int'(bus.data_bits[c*4 +: 4]);
        if (d == 0) d = 1;
        if (d > DM) d = DM;
        m_D[c] = d;
`ifdef UART_FRAME_CNT_PARITY_EN
        m_P[c] = int'(bus.parity_en[c]);
`else
        m_P[c] = 0;
`endif
        m_S[c] = bus.two_stop[c] ? 2 : 1;
        m_run[c] = 1; m_cnt[c] = 0; m_done[c] = 0;
      end else if (tk[c] && m_run[c]) begin
        if (m_cnt[c] == m_D[c] + m_P[c] + m_S[c]) begin
          m_done[c] = 1; m_run[c] = 0; m_cnt[c] = 0;
        end else begin
          m_cnt[c]++; m_done[c] = 0;
        end
      end else begin
        m_done[c] = 0;
      end
      sb.push_back(model_obs(c));
    end
    @(posedge clock);
    #1;
    for (int c = 0; c < CH; c++) begin
      e = sb.pop_front();
      check_obs($sformatf("%s.ch%0d", cur_tag, c), dut_obs(c), e);
      if (bus.done[c]) done_cnt[c]++;
    end
    bus.start = '0; bus.abort = '0; bus.tick = '0;
  endtask

  // Start a frame on one channel and tick until done (bounded).
  task automatic run_frame(input int c, input int db, input int pe, input int ts,
                           input int exp_len, input int exp_par, input string tag);
    int n;
    bit fin, par;
    cur_tag = tag;
    fmt(c, db, pe, ts);
    step(onehot(c), '0, '0);
    n = 0; fin = 0; par = 0;
    while (!fin && n < 20) begin
      step('0, '0, onehot(c));
      n++;
      if (bus.phase[c*2 +: 2] == 2'd2) par = 1;
      if (bus.done[c]) fin = 1;
    end
    check_int({tag, ".len"}, n, exp_len);
    check_int({tag, ".parity_seen"}, int'(par), exp_par);
    step('0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.start = '0; bus.abort = '0; bus.tick = '0;
    bus.data_bits = '0; bus.parity_en = '0; bus.two_stop = '0;
    model_reset();
    for (int c = 0; c < CH; c++) done_cnt[c] = 0;
    #1;
    for (int c = 0; c < CH; c++)
      check_obs($sformatf("reset.ch%0d", c), dut_obs(c), obs_t'('0));
    @(negedge clock);
    reset_n = 1'b1;
    cur_tag = "idle";
    step('0, '0, 2'b11);

    // 8N1: L = 10, exactly one done pulse
    done_cnt[0] = 0;
    run_frame(0, 8, 0, 0, 10, 0, "8N1");
    check_int("8N1.done_pulses", done_cnt[0], 1);

    // 7 data, parity, two stop
`ifdef UART_FRAME_CNT_PARITY_EN
    run_frame(0, 7, 1, 1, 11, 1, "7P2");
`else
    run_frame(0, 7, 1, 1, 10, 0, "7P2");
`endif

    // data_bits clamping
    run_frame(1, 0, 0, 0, 3, 0, "db0");
    run_frame(1, 15, 0, 0, 11, 0, "db15");

    // abort at bit 4: no done, ticks ignored afterwards
    cur_tag = "abort";
    fmt(0, 8, 0, 0);
    done_cnt[0] = 0;
    step(2'b01, '0, '0);
    repeat (4) step('0, '0, 2'b01);
    check_int("abort.idx_before", int'(bus.bit_idx[0 +: CW]), 4);
    step('0, 2'b01, 2'b01);
    check_int("abort.busy", int'(bus.busy[0]), 0);
    repeat (3) step('0, '0, 2'b01);
    check_int("abort.done_pulses", done_cnt[0], 0);

    // restart coincident with final tick
    cur_tag = "restart";
    fmt(1, 5, 0, 0);
    step(2'b10, '0, '0);
    repeat (6) step('0, '0, 2'b10);
    check_int("restart.last_bit", int'(bus.last_bit[1]), 1);
    step(2'b10, '0, 2'b10);
    check_int("restart.done", int'(bus.done[1]), 0);
    check_int("restart.idx", int'(bus.bit_idx[CW +: CW]), 0);
    check_int("restart.busy", int'(bus.busy[1]), 1);
    repeat (8) step('0, '0, 2'b10);

    // two channels, different formats, interleaved ticks
    cur_tag = "interleave";
    fmt(0, 8, 0, 0);
    fmt(1, 5, 1, 1);
    done_cnt[0] = 0; done_cnt[1] = 0;
    step(2'b11, '0, '0);
    for (i = 0; i < 30; i++) begin
      case (i % 3)
        0:       step('0, '0, 2'b01);
        1:       step('0, '0, 2'b10);
        default: step('0, '0, 2'b11);
      endcase
    end
    check_int("interleave.done0", done_cnt[0], 1);
    check_int("interleave.done1", done_cnt[1], 1);

    // asynchronous reset mid-frame (count 5), between clock edges
    cur_tag = "areset";
    fmt(0, 8, 0, 0);
    step(2'b01, '0, '0);
    repeat (5) step('0, '0, 2'b01);
    check_int("areset.idx_before", int'(bus.bit_idx[0 +: CW]), 5);
    #2;
    reset_n = 1'b0;
    #1;
    for (int c = 0; c < CH; c++)
      check_obs($sformatf("areset.ch%0d", c), dut_obs(c), obs_t'('0));
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    cur_tag = "post_reset";
    step('0, '0, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_frame_counter.md
# uart_frame_counter

Multi-channel, parametrised UART frame bit counter that tracks the position within a serial frame (start, data, optional parity, stop) for each TX/RX engine. It sits between the baud-tick generator and the shift registers of each UART channel. It tells the channel FSM which bit is on the wire and when the frame is complete. Frame format is programmable per channel and latched at frame start.

## Interface
Parameters:
- CHANNELS, 2, number of independent counters (channel 0 = TX, 1 = RX by convention)
- DATA_MAX, 9, maximum data bits per frame (≥ 5)
- CNT_W, $clog2(DATA_MAX+4), width of bit index (derived, not overridable)

Ports (per-channel signals packed, channel c at [c] or [c*W +: W]):
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  CHANNELS  begin frame; latches format, count←0
- abort  in  CHANNELS  synchronous cancel; return to IDLE, no done
- tick  in  CHANNELS  one-cycle baud/bit strobe; advances count
- data_bits  in  CHANNELS*4  data bit count; 0 treated as 1, >DATA_MAX treated as DATA_MAX
- parity_en  in  CHANNELS  insert one parity bit after data
- two_stop  in  CHANNELS  0 = one stop bit, 1 = two stop bits
- busy  out  CHANNELS  frame in progress (state RUN)
- done  out  CHANNELS  one-cycle pulse, frame complete
- last_bit  out  CHANNELS  combinational: RUN and count == L−1
- bit_idx  out  CHANNELS*CNT_W  current bit position in frame
- phase  out  CHANNELS*2  0 START, 1 DATA, 2 PARITY, 3 STOP

## Operation
- Per channel: 2-state FSM IDLE/RUN; registered count, latched D (clamped data bits), P (parity), S (1 or 2). Frame length L = 1 + D + P + S.
- Priority each edge: abort > start > tick.
- abort: state←IDLE, count←0, done←0.
- start (IDLE or RUN): latch D/P/S, count←0, state←RUN; restart mid-frame allowed, no done for aborted frame.
- tick in RUN: if count == L−1 → done←1, count←0, state←IDLE; else count←count+1, done←0.
- tick in IDLE: ignored. Format inputs changed during RUN: ignored until next start.
- done is cleared on every edge where it is not re-set (exactly one cycle wide).
- phase (from count, latched format): 0 → START; 1..D → DATA; D+1 when P → PARITY; remainder → STOP. In IDLE phase = START, bit_idx = 0.
- Arithmetic unsigned, CNT_W bits; count never exceeds L−1, no wrap.
- Channels fully independent; no shared state.

## Timing
- Reset (reset_n low, asynchronous): state IDLE, count 0, busy 0, done 0, bit_idx 0, phase 0, last_bit 0, latched format D=1, P=0, S=1.
- start sampled at edge k → busy=1, bit_idx=0 after edge k.
- n-th tick after start → bit_idx=n after that edge.
- Final tick (count L−1) at edge m → done=1, busy=0, bit_idx=0 for cycle after m; done=0 after m+1.
- start coincident with final tick: restart wins, done stays 0, busy stays 1.
- last_bit combinational; zero latency from count.

## Configuration
- Macro UART_FRAME_CNT_PARITY_EN.
- Defined: parity_en honoured as above.
- Undefined: parity_en ignored, P forced 0, phase never 2; parity logic not synthesised.

## Test plan
- Reset: hold reset_n low mid-frame (count 5) → all outputs 0 immediately, without a clock edge.
- data_bits=8, parity_en=0, two_stop=0, start then 10 ticks → bit_idx 0..9, phase 0,1×8,3; done pulses once after 10th tick, busy falls same cycle.
- data_bits=7, parity_en=1, two_stop=1 (macro defined) → L=11; phase=2 at bit_idx 8; done after 11th tick; macro undefined → L=10, phase never 2.
- data_bits=0 → L=3 (treated as 1); data_bits=15 with DATA_MAX=9 → L=11.
- abort at bit_idx 4 → busy 0, no done; start+tick on final bit same cycle → done 0, bit_idx 0, busy 1.
- Channels 0 and 1 run different formats with interleaved ticks → independent counts, no cross-talk.
